// File: rtl/seg7_scan_if.sv
// Signal bundle between the stopwatch/display source and the seven-segment scan controller.
interface seg7_scan_if;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        blank_en;
    logic        sel_a;
    logic        sel_b;
    logic        sel_en;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output enable, digits, dp_mask, blank_en,
        input  sel_a, sel_b, sel_en, seg, dp
    );

    modport slave (
        input  enable, digits, dp_mask, blank_en,
        output sel_a, sel_b, sel_en, seg, dp
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scan controller: per-digit refresh prescaler, frame-coherent
// nibble snapshot, leading-zero blanking and registered decoder/cathode drive.
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam int            PW     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PLAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PGUARD = PW'(GUARD);

    logic [PW-1:0] pcnt;
    logic [1:0]    idx;
    logic [15:0]   snap_d;
    logic [3:0]    snap_dp;
    logic          snap_bl;

    logic          tick;
    logic          load;
    logic [15:0]   cur_d;
    logic [3:0]    cur_dp;
    logic          cur_bl;
    logic [3:0]    nib;
    logic          blank;
    logic          lit;
    logic [6:0]    glyph;

    assign tick = (pcnt == PLAST);
    assign load = bus.enable && (idx == 2'd0) && (pcnt == '0);

    // Bypass the snapshot being loaded so the first slot of a frame already shows the new data.
    assign cur_d  = load ? bus.digits   : snap_d;
    assign cur_dp = load ? bus.dp_mask  : snap_dp;
    assign cur_bl = load ? bus.blank_en : snap_bl;
    assign nib    = cur_d[idx*4 +: 4];

    always_comb begin
        blank = 1'b0;
        if (cur_bl) begin
            case (idx)
                2'd3:    blank = (cur_d[15:12] == 4'h0);
                2'd2:    blank = (cur_d[15:8]  == 8'h00);
                2'd1:    blank = (cur_d[15:4]  == 12'h000);
                default: blank = 1'b0;
            endcase
        end
    end

    assign lit = bus.enable && (pcnt >= PGUARD) && !blank;

    always_comb begin
        glyph = 7'h7F;
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt       <= '0;
            idx        <= 2'd0;
            snap_d     <= 16'h0000;
            snap_dp    <= 4'h0;
            snap_bl    <= 1'b0;
            bus.sel_a  <= 1'b0;
            bus.sel_b  <= 1'b0;
            bus.sel_en <= 1'b0;
            bus.seg    <= 7'h7F;
            bus.dp     <= 1'b1;
        end else begin
            if (bus.enable) begin
                pcnt <= tick ? '0 : pcnt + PW'(1);
                if (tick)
                    idx <= idx + 2'd1;
                if (load) begin
                    snap_d  <= bus.digits;
                    snap_dp <= bus.dp_mask;
                    snap_bl <= bus.blank_en;
                end
            end
            // idx only moves while enabled, so this also holds the select lines when frozen.
            bus.sel_a  <= idx[1];
            bus.sel_b  <= idx[0];
            bus.sel_en <= lit;
            bus.seg    <= lit ? glyph : 7'h7F;
            bus.dp     <= lit ? ~cur_dp[idx] : 1'b1;
        end
    end
endmodule
